timer_ctrl: RTL
===============

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per count tick (1 s at 50 MHz); legal range 2..2^26.
REQ-002 Parameter DEB_CYCLES, default 1000000, stable cycles required to accept a button level (20 ms).
REQ-003 Parameter MAX_COUNT, default 99, terminal value of the controlled counter.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sw_en  input  1  enable switch; low forces OFF.
REQ-007 btn_start_n  input  1  start/pause key, active-low, asynchronous to clk.
REQ-008 btn_clear_n  input  1  clear key, active-low, asynchronous to clk.
REQ-009 mode_oneshot  input  1  1 = stop at MAX_COUNT; 0 = free-run with wrap.
REQ-010 cnt_val  input  7  current value of the counter datapath.
REQ-011 cnt_inc  output  1  one-cycle increment strobe to the datapath.
REQ-012 cnt_clr  output  1  one-cycle clear strobe to the datapath.
REQ-013 endone  output  1  one-cycle pulse on the terminal tick.
REQ-014 disp_blank  output  1  high while in OFF; display blanks all segments.
REQ-015 state  output  3  FSM state: OFF=0, IDLE=1, RUN=2, PAUSE=3, DONE=4.

Function
REQ-016 Each key passes through a 2-FF synchroniser; a press is a single-cycle event on the high-to-low transition of the conditioned level.
REQ-017 26-bit prescaler counts only in RUN and holds its value in PAUSE; tick = RUN && prescaler==TICK_DIV-1, after which prescaler returns to 0.
REQ-018 Prescaler clears to 0 on entry to RUN from IDLE or DONE, on any clear press, and in OFF.
REQ-019 sw_en==0 in any state: next state OFF; cnt_clr pulses on the first cycle of OFF only.
REQ-020 OFF -> IDLE when sw_en==1; key presses in OFF are ignored.
REQ-021 IDLE: start press -> RUN.
REQ-022 RUN: start press -> PAUSE; tick with cnt_val<MAX_COUNT -> cnt_inc, stay RUN.
REQ-023 RUN, tick with cnt_val==MAX_COUNT: oneshot -> endone, no cnt_inc, DONE; free-run -> endone and cnt_inc (datapath wraps to 0), stay RUN.
REQ-024 PAUSE: start press -> RUN, prescaler resumes from held value.
REQ-025 DONE: start press -> cnt_clr, RUN from count 0.
REQ-026 Clear press in IDLE, RUN, PAUSE or DONE -> cnt_clr, next state IDLE.
REQ-027 Priority, same cycle: sw_en low > clear press > tick > start press; tick with start press in RUN issues cnt_inc/endone then enters PAUSE; tick with clear press issues no cnt_inc and no endone.
REQ-028 cnt_inc, cnt_clr and endone are registered, never high longer than one cycle, and cnt_inc and cnt_clr are never high together.
REQ-029 mode_oneshot is sampled only at the terminal tick; changing it mid-run is legal.

Reset
REQ-030 rst_n low asynchronously: state OFF, prescaler 0, cnt_inc/cnt_clr/endone 0, disp_blank 1, synchroniser and debounce stages at released level (1), debounce counters 0.
REQ-031 Reset release is synchronised internally; the first state change is no earlier than the second clk edge after rst_n rises.

Configuration
REQ-032 Macro TIMER_CTRL_DEBOUNCE_EN defined: after synchronisation each key level is accepted only after DEB_CYCLES consecutive equal samples; a press therefore follows a held key by DEB_CYCLES+2 to DEB_CYCLES+3 cycles.
REQ-033 Macro undefined: no debounce counters; press event follows the synchronised edge directly (2-3 cycles latency); DEB_CYCLES is unused.

Verification (TICK_DIV=4, DEB_CYCLES=3, MAX_COUNT=99, bench models a 0..99 counter on cnt_inc/cnt_clr)
REQ-034 Reset, sw_en=1, start press -> state RUN; cnt_inc every 4 cycles; cnt_val 0->5 after 20 cycles.
REQ-035 oneshot=1, run to cnt_val=99 -> next tick endone=1, cnt_inc=0, state DONE, cnt_val stays 99; start press -> cnt_clr, RUN, cnt_val 0.
REQ-036 oneshot=0, cnt_val=99 at tick -> endone and cnt_inc same cycle, cnt_val 0, state RUN.
REQ-037 Pause 2 cycles after a tick, hold 50 cycles, resume -> next cnt_inc exactly 2 cycles after resume (prescaler held).
REQ-038 Start and clear pressed same cycle coinciding with tick -> cnt_clr only, no cnt_inc, state IDLE; sw_en dropped mid-RUN -> OFF, disp_blank=1, one cnt_clr.
REQ-039 With TIMER_CTRL_DEBOUNCE_EN: 2-cycle key glitch -> no state change; 10-cycle hold -> exactly one press.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// Counter datapath bus: timer_ctrl (master) issues inc/clr strobes and observes
// the current count held by the external 0..MAX_COUNT counter (slave).
interface timer_ctrl_if;
  logic [6:0] cnt_val;
  logic       cnt_inc;
  logic       cnt_clr;

  modport master (input cnt_val, output cnt_inc, output cnt_clr);
  modport slave  (output cnt_val, input cnt_inc, input cnt_clr);
endinterface

// File: rtl/timer_ctrl.sv
// Start/pause/clear timer controller with prescaled tick and key conditioning.
// Optional key debounce is enabled by defining TIMER_CTRL_DEBOUNCE_EN.

module timer_ctrl_key #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);
  logic [1:0] sync_q;

  // Two-stage synchroniser for the asynchronous key, idle level 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
    end
  end

`ifdef TIMER_CTRL_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             deb_lvl_q, deb_lvl_d;
  logic             press_q, press_d;

  // Accept a new level after DEB_CYCLES consecutive differing samples
  always_comb begin
    deb_cnt_d = {DEB_W{1'b0}};
    deb_lvl_d = deb_lvl_q;
    press_d   = 1'b0;
    if (sync_q[1] != deb_lvl_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_lvl_d = sync_q[1];
        press_d   = ~sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + {{(DEB_W-1){1'b0}}, 1'b1};
      end
    end else begin
      deb_cnt_d = {DEB_W{1'b0}};
    end
  end

  // Debounce state and registered press event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= {DEB_W{1'b0}};
      deb_lvl_q <= 1'b1;
      press_q   <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      deb_lvl_q <= deb_lvl_d;
      press_q   <= press_d;
    end
  end

  assign press_o = press_q;
`else
  logic prev_q;

  // Previous synchronised level for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sync_q[1];
    end
  end

  assign press_o = prev_q & ~sync_q[1];
`endif
endmodule

module timer_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000,
  parameter int MAX_COUNT  = 99
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sw_en,
  input  logic         btn_start_n,
  input  logic         btn_clear_n,
  input  logic         mode_oneshot,
  timer_ctrl_if.master cnt_bus,
  output logic         endone,
  output logic         disp_blank,
  output logic [2:0]   state
);
  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [25:0] PRESC_LAST = 26'(TICK_DIV - 1);
  localparam logic [6:0]  CNT_LAST   = 7'(MAX_COUNT);

  state_e      state_q, state_d;
  logic [25:0] presc_q, presc_d;
  logic [1:0]  rst_sync_q;
  logic        inc_q, inc_d, clr_q, clr_d, end_q, end_d, blank_q, blank_d;
  logic        start_press_s, clear_press_s, tick_s, terminal_s, rst_done_s;

  timer_ctrl_key #(.DEB_CYCLES(DEB_CYCLES)) u_key_start (
    .clk(clk), .rst_n(rst_n), .key_n_i(btn_start_n), .press_o(start_press_s)
  );

  timer_ctrl_key #(.DEB_CYCLES(DEB_CYCLES)) u_key_clear (
    .clk(clk), .rst_n(rst_n), .key_n_i(btn_clear_n), .press_o(clear_press_s)
  );

  // Reset-release synchroniser; the FSM stays frozen until it has filled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_done_s = rst_sync_q[1];
  assign tick_s     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
  assign terminal_s = (cnt_bus.cnt_val >= CNT_LAST);

  // Next state, prescaler and strobe decode; priority sw_en > clear > tick > start
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    inc_d   = 1'b0;
    clr_d   = 1'b0;
    end_d   = 1'b0;
    if (!rst_done_s) begin
      state_d = state_q;
    end else if (!sw_en) begin
      state_d = ST_OFF;
      presc_d = 26'd0;
      clr_d   = (state_q != ST_OFF);
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_IDLE;
          presc_d = 26'd0;
        end
        ST_IDLE: begin
          if (clear_press_s) begin
            clr_d   = 1'b1;
            presc_d = 26'd0;
          end else if (start_press_s) begin
            state_d = ST_RUN;
            presc_d = 26'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (clear_press_s) begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
            presc_d = 26'd0;
          end else if (tick_s) begin
            presc_d = 26'd0;
            if (terminal_s && mode_oneshot) begin
              end_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              // Free-run at the terminal value relies on the datapath wrapping to 0
              end_d   = terminal_s;
              inc_d   = 1'b1;
              state_d = start_press_s ? ST_PAUSE : ST_RUN;
            end
          end else begin
            presc_d = presc_q + 26'd1;
            state_d = start_press_s ? ST_PAUSE : ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (clear_press_s) begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
            presc_d = 26'd0;
          end else if (start_press_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_DONE: begin
          if (clear_press_s) begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
            presc_d = 26'd0;
          end else if (start_press_s) begin
            state_d = ST_RUN;
            clr_d   = 1'b1;
            presc_d = 26'd0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_OFF;
          presc_d = 26'd0;
        end
      endcase
    end
    blank_d = (state_d == ST_OFF);
  end

  // State, prescaler and registered output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      presc_q <= 26'd0;
      inc_q   <= 1'b0;
      clr_q   <= 1'b0;
      end_q   <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      inc_q   <= inc_d;
      clr_q   <= clr_d;
      end_q   <= end_d;
      blank_q <= blank_d;
    end
  end

  assign cnt_bus.cnt_inc = inc_q;
  assign cnt_bus.cnt_clr = clr_q;
  assign endone          = end_q;
  assign disp_blank      = blank_q;
  assign state           = state_q;
endmodule
